// File: rtl/gpif_socket_sched.sv
// gpif_socket_sched: schedules the shared FX3 GPIF data bus between sockets IN0, IN1, OUT0 and OUT1
//   main_clk       clock
//   rst            synchronous reset, active-low
//   i_req[3:0]     per-socket request, [0]=IN0 [1]=IN1 [2]=OUT0 [3]=OUT1
//   i_sock_rdy[3:0] FX3 ready flags, same bit order
//   i_xfer_stb     one word moved on the granted socket this cycle
//   i_xfer_last    requester ends a short packet (ACTIVE only)
//   o_socket_addr  GPIF socket address of the granted socket
//   o_grant        one-hot grant
//   o_activate     data path enable for the granted socket
//   o_pkt_end      one-cycle packet-end pulse for short IN packets
//   o_busy         scheduler not idle
//   o_xfer_count   words moved in the current/last grant
// Build option GPIF_SCHED_RR_EN: round-robin arbitration instead of fixed OUT0>OUT1>IN0>IN1 priority.
module gpif_socket_sched #(
   parameter int PACKET_WORDS = 128,
   parameter int COUNT_W      = 24,
   parameter int ADDR_SETUP   = 2,
   parameter int TURN_GAP     = 1
) (
   input  logic               main_clk,
   input  logic               rst,
   input  logic [3:0]         i_req,
   input  logic [3:0]         i_sock_rdy,
   input  logic               i_xfer_stb,
   input  logic               i_xfer_last,
   output logic [1:0]         o_socket_addr,
   output logic [3:0]         o_grant,
   output logic               o_activate,
   output logic               o_pkt_end,
   output logic               o_busy,
   output logic [COUNT_W-1:0] o_xfer_count
);
   typedef enum logic [2:0] {IDLE, ADDR, ACTIVE, FLUSH, GAP} state_t;
   state_t state_q, state_d;
   logic [1:0] idx_q, idx_d, win;
   logic [3:0] grant_q, grant_d, elig;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic [7:0] tmr_q, tmr_d;
   logic act_q, pkt_end_q, sel_req, sel_rdy;
   assign elig    = i_req & i_sock_rdy;
   assign sel_req = i_req[idx_q];
   assign sel_rdy = i_sock_rdy[idx_q];
`ifdef GPIF_SCHED_RR_EN
   logic [1:0] rr_q, cand;
   // search from the socket after the last winner; descending loop so the nearest candidate wins
   always_comb begin
      win  = rr_q;
      cand = rr_q;
      for (int k = 3; k >= 0; k--) begin
         cand = rr_q + 2'd1 + 2'(k);
         if (elig[cand]) win = cand;
      end
   end
   always_ff @(posedge main_clk) begin
      if (!rst) rr_q <= 2'd3;
      else if (state_q == IDLE && state_d == ADDR) rr_q <= win;
   end
`else
   assign win = elig[2] ? 2'd2 : elig[3] ? 2'd3 : elig[0] ? 2'd0 : 2'd1;
`endif
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      case (state_q)
         IDLE:   if (|elig) begin
                    state_d = ADDR;
                    idx_d   = win;
                    grant_d = 4'b0001 << win;
                    cnt_d   = '0;
                 end
         ADDR:   if (tmr_q == 8'(ADDR_SETUP - 1)) state_d = (sel_rdy & sel_req) ? ACTIVE : GAP;
                 else tmr_d = tmr_q + 8'd1;
         ACTIVE: begin
                    if (i_xfer_stb) cnt_d = cnt_q + COUNT_W'(cnt_q != '1);
                    if (i_xfer_stb && cnt_q == COUNT_W'(PACKET_WORDS - 1)) state_d = GAP;
                    else if (i_xfer_last || !sel_req) state_d = FLUSH;
                    else if (!sel_rdy) state_d = GAP;
                 end
         FLUSH:  state_d = GAP;
         GAP:    if (tmr_q == 8'(TURN_GAP - 1)) state_d = IDLE;
                 else tmr_d = tmr_q + 8'd1;
         default: state_d = IDLE;
      endcase
      // every state entry restarts the dwell timer; the grant is withdrawn for the turnaround gap
      if (state_d != state_q) tmr_d = '0;
      if (state_d == GAP) grant_d = '0;
   end
   always_ff @(posedge main_clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         grant_q   <= '0;
         cnt_q     <= '0;
         tmr_q     <= '0;
         act_q     <= 1'b0;
         pkt_end_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         tmr_q     <= tmr_d;
         act_q     <= state_d == ACTIVE;
         // only IN sockets (idx 0/1) that moved data need an explicit short-packet commit
         pkt_end_q <= state_d == FLUSH && !idx_q[1] && cnt_d != '0;
      end
   end
   assign o_socket_addr = idx_q;
   assign o_grant       = grant_q;
   assign o_activate    = act_q;
   assign o_pkt_end     = pkt_end_q;
   assign o_busy        = state_q != IDLE;
   assign o_xfer_count  = cnt_q;
endmodule

// File: tb/tb_gpif_socket_sched.sv
// tb_gpif_socket_sched: directed vector table plus multi-cycle sequences for gpif_socket_sched
module tb_gpif_socket_sched;
   logic main_clk = 1'b0, rst = 1'b0, i_xfer_stb = 1'b0, i_xfer_last = 1'b0;
   logic [3:0] i_req = '0, i_sock_rdy = '0;
   logic [1:0] o_socket_addr;
   logic [3:0] o_grant;
   logic o_activate, o_pkt_end, o_busy, pe_seen;
   logic [23:0] o_xfer_count;
   int n_chk = 0, n_pass = 0, e;
   typedef struct {
      int req, rdy, stb, last, grant, addr, act, pe, busy, cnt;
   } vec_t;
   vec_t vt[$];

   gpif_socket_sched dut (
      .main_clk(main_clk), .rst(rst), .i_req(i_req), .i_sock_rdy(i_sock_rdy),
      .i_xfer_stb(i_xfer_stb), .i_xfer_last(i_xfer_last), .o_socket_addr(o_socket_addr),
      .o_grant(o_grant), .o_activate(o_activate), .o_pkt_end(o_pkt_end),
      .o_busy(o_busy), .o_xfer_count(o_xfer_count)
   );

   always #5 main_clk = ~main_clk;

   task automatic step();
      @(posedge main_clk);
      #1;
   endtask

   task automatic chk(input string n, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", n, act, exp);
   endtask

   task automatic chk_all(input string n, input int grant, input int addr, input int act,
                          input int pe, input int busy, input int cnt);
      chk({n, ".grant"}, int'(o_grant), grant);
      chk({n, ".addr"}, int'(o_socket_addr), addr);
      chk({n, ".activate"}, int'(o_activate), act);
      chk({n, ".pkt_end"}, int'(o_pkt_end), pe);
      chk({n, ".busy"}, int'(o_busy), busy);
      chk({n, ".count"}, int'(o_xfer_count), cnt);
   endtask

   initial begin
      // req rdy stb last | grant addr act pe busy cnt
      vt.push_back('{2, 2, 0, 0, 2, 1, 0, 0, 1, 0});
      vt.push_back('{2, 2, 1, 0, 2, 1, 0, 0, 1, 0});
      vt.push_back('{2, 2, 0, 0, 2, 1, 1, 0, 1, 0});
      vt.push_back('{2, 2, 1, 0, 2, 1, 1, 0, 1, 1});
      vt.push_back('{2, 2, 1, 0, 2, 1, 1, 0, 1, 2});
      vt.push_back('{2, 2, 1, 0, 2, 1, 1, 0, 1, 3});
      vt.push_back('{2, 2, 1, 0, 2, 1, 1, 0, 1, 4});
      vt.push_back('{2, 2, 1, 1, 2, 1, 0, 1, 1, 5});
      vt.push_back('{0, 0, 1, 1, 0, 1, 0, 0, 1, 5});
      vt.push_back('{0, 0, 1, 0, 0, 1, 0, 0, 0, 5});
      vt.push_back('{0, 0, 1, 1, 0, 1, 0, 0, 0, 5});
      vt.push_back('{4, 4, 0, 0, 4, 2, 0, 0, 1, 0});
      vt.push_back('{4, 4, 1, 1, 4, 2, 0, 0, 1, 0});
      vt.push_back('{4, 4, 0, 0, 4, 2, 1, 0, 1, 0});
      vt.push_back('{4, 4, 1, 0, 4, 2, 1, 0, 1, 1});
      vt.push_back('{4, 4, 1, 1, 4, 2, 0, 0, 1, 2});
      vt.push_back('{0, 0, 0, 0, 0, 2, 0, 0, 1, 2});
      vt.push_back('{0, 0, 0, 0, 0, 2, 0, 0, 0, 2});
      vt.push_back('{1, 1, 0, 0, 1, 0, 0, 0, 1, 0});
      vt.push_back('{1, 1, 0, 0, 1, 0, 0, 0, 1, 0});
      vt.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 1, 0});
      vt.push_back('{1, 0, 1, 0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{1, 1, 0, 0, 1, 0, 0, 0, 1, 0});
      vt.push_back('{1, 1, 0, 0, 1, 0, 0, 0, 1, 0});
      vt.push_back('{1, 1, 0, 0, 1, 0, 1, 0, 1, 0});
      vt.push_back('{0, 1, 0, 0, 1, 0, 0, 0, 1, 0});
      vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
      vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
      vt.push_back('{1, 1, 0, 0, 1, 0, 0, 0, 1, 0});
      vt.push_back('{1, 1, 0, 0, 1, 0, 0, 0, 1, 0});
      vt.push_back('{1, 1, 0, 0, 1, 0, 1, 0, 1, 0});
      vt.push_back('{1, 0, 1, 1, 1, 0, 0, 1, 1, 1});
      vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 1});
      vt.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1});

      repeat (3) step();
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      foreach (vt[i]) begin
         i_req = 4'(vt[i].req);
         i_sock_rdy = 4'(vt[i].rdy);
         i_xfer_stb = vt[i].stb != 0;
         i_xfer_last = vt[i].last != 0;
         step();
         chk_all($sformatf("vec%0d", i), vt[i].grant, vt[i].addr, vt[i].act, vt[i].pe, vt[i].busy, vt[i].cnt);
      end

      // full packet on IN0: address next edge, activate two edges later, ends on the 128th word
      i_req = 4'h1; i_sock_rdy = 4'h1; i_xfer_stb = 1'b0; i_xfer_last = 1'b0;
      step();
      chk_all("full.addr", 1, 0, 0, 0, 1, 0);
      step();
      chk("full.act_wait", int'(o_activate), 0);
      step();
      chk("full.act_on", int'(o_activate), 1);
      pe_seen = 1'b0;
      i_xfer_stb = 1'b1;
      for (int i = 1; i <= 128; i++) begin
         step();
         pe_seen |= o_pkt_end;
         if (i < 128) chk($sformatf("full.act%0d", i), int'(o_activate), 1);
         chk($sformatf("full.cnt%0d", i), int'(o_xfer_count), i);
      end
      chk_all("full.end", 0, 0, 0, 0, 1, 128);
      i_xfer_stb = 1'b0; i_req = 4'h0;
      step();
      pe_seen |= o_pkt_end;
      chk_all("full.idle", 0, 0, 0, 0, 0, 128);
      chk("full.pe_never", int'(pe_seen), 0);

      // ready drop on OUT0 after 40 words
      i_req = 4'h4; i_sock_rdy = 4'h4;
      repeat (3) step();
      chk("rdrop.act_on", int'(o_activate), 1);
      i_xfer_stb = 1'b1;
      repeat (40) step();
      chk("rdrop.cnt40", int'(o_xfer_count), 40);
      i_xfer_stb = 1'b0; i_sock_rdy = 4'h0;
      step();
      chk_all("rdrop.end", 0, 2, 0, 0, 1, 40);
      i_req = 4'h0;
      step();
      chk("rdrop.idle", int'(o_busy), 0);

      // reset in the middle of an IN1 transfer with last pending
      i_req = 4'h2; i_sock_rdy = 4'h2;
      repeat (3) step();
      i_xfer_stb = 1'b1;
      repeat (3) step();
      chk("mrst.pre_cnt", int'(o_xfer_count), 3);
      chk("mrst.pre_act", int'(o_activate), 1);
      rst = 1'b0; i_xfer_last = 1'b1;
      step();
      chk_all("mrst.edge1", 0, 0, 0, 0, 0, 0);
      step();
      chk("mrst.pe2", int'(o_pkt_end), 0);
      step();
      chk("mrst.pe3", int'(o_pkt_end), 0);
      rst = 1'b1; i_req = 4'h0; i_sock_rdy = 4'h0; i_xfer_stb = 1'b0; i_xfer_last = 1'b0;
      step();
      chk_all("mrst.after", 0, 0, 0, 0, 0, 0);

      // arbitration with all four sockets eligible; each grant closed by a zero-length short packet
      i_req = 4'hf; i_sock_rdy = 4'hf;
      for (int g = 0; g < 4; g++) begin
`ifdef GPIF_SCHED_RR_EN
         e = g;
`else
         e = 2;
`endif
         step();
         chk($sformatf("arb%0d.addr", g), int'(o_socket_addr), e);
         chk($sformatf("arb%0d.grant", g), int'(o_grant), 1 << e);
         repeat (2) step();
         chk($sformatf("arb%0d.act", g), int'(o_activate), 1);
         i_xfer_last = 1'b1;
         step();
         i_xfer_last = 1'b0;
         chk($sformatf("arb%0d.pe", g), int'(o_pkt_end), 0);
         repeat (2) step();
      end
      i_req = 4'h0; i_sock_rdy = 4'h0;
      step();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
